// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : Next-PC decision stage. Resolves branch ops against a
//                registered ALU flag and a jump-target lookup table, drives
//                the program counter's BranchAbs/Target pair combinationally,
//                and runs the Start/Done program handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_ctrl #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   ProgCtr,
    input  logic [1:0]        BrOp,
    input  logic              BrRel,
    input  logic [LUT_AW-1:0] LutIdx,
    input  logic              FlagWe,
    input  logic              ALU_flag,
    input  logic              Halt,
    input  logic              LutWe,
    input  logic [LUT_AW-1:0] LutWAddr,
    input  logic [PC_W-1:0]   LutWData,
    output logic              BranchAbs,
    output logic [PC_W-1:0]   Target,
    output logic              Done,
    output logic              Flag
);

    localparam int C_LUT_N = 1 << LUT_AW;

    localparam logic [1:0] C_BR_NONE   = 2'b00;
    localparam logic [1:0] C_BR_ALWAYS = 2'b01;
    localparam logic [1:0] C_BR_IF_SET = 2'b10;
    localparam logic [1:0] C_BR_IF_CLR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_flag;
    logic              r_done;
    logic [PC_W-1:0]   r_lut [C_LUT_N];

    logic [PC_W-1:0]   w_lut_rd;
    logic [PC_W-1:0]   w_rel_tgt;
    logic              w_taken;

    // Asynchronous table read: a same-cycle write is only visible next cycle.
    assign w_lut_rd  = r_lut[LutIdx];
    // Entry and PC share a width, so a plain modular add is the sign-extended
    // relative sum with wraparound.
    assign w_rel_tgt = ProgCtr + w_lut_rd;

    // Branch condition uses the flag as registered before this cycle's update.
    always_comb begin
        w_taken = 1'b0;
        case (BrOp)
            C_BR_NONE:   w_taken = 1'b0;
            C_BR_ALWAYS: w_taken = 1'b1;
            C_BR_IF_SET: w_taken = r_flag;
            C_BR_IF_CLR: w_taken = ~r_flag;
            default:     w_taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and PC-control outputs; idle and halt hold the PC by reloading it.
    always_comb begin
        w_next    = r_state;
        BranchAbs = 1'b0;
        Target    = w_lut_rd;
        case (r_state)
            ST_IDLE: begin
                BranchAbs = 1'b1;
                Target    = ProgCtr;
                if (Start) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                BranchAbs = 1'b0;
                if (!Start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    BranchAbs = 1'b1;
                    Target    = ProgCtr;
                end else if (w_taken) begin
                    BranchAbs = 1'b1;
                    Target    = BrRel ? w_rel_tgt : w_lut_rd;
                end
                if (Start) begin
                    w_next = ST_START;
                end else if (Halt) begin
                    w_next = ST_HALT;
                end
            end
            ST_HALT: begin
                BranchAbs = 1'b1;
                Target    = ProgCtr;
                if (Start) begin
                    w_next = ST_START;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Flag and Done: both cleared when a program starts; Done set on halt.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flag <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_next == ST_START) begin
                r_done <= 1'b0;
            end else if (r_state == ST_RUN && Halt) begin
                r_done <= 1'b1;
            end
            if (r_state == ST_START) begin
                r_flag <= 1'b0;
            end else if (r_state == ST_RUN && FlagWe) begin
                r_flag <= ALU_flag;
            end
        end
    end

    // Jump-target table: cleared by reset, writable in every state otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < C_LUT_N; i++) begin
                r_lut[i] <= '0;
            end
        end else if (LutWe) begin
            r_lut[LutWAddr] <= LutWData;
        end
    end

    assign Done = r_done;
    assign Flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Directed self-checking bench for branch_ctrl with a simple
//                program-counter model closing the loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;

    logic              Clk = 1'b0;
    logic              Reset, Start, BrRel, FlagWe, ALU_flag, Halt, LutWe;
    logic [PC_W-1:0]   ProgCtr = '0;
    logic [1:0]        BrOp;
    logic [LUT_AW-1:0] LutIdx, LutWAddr;
    logic [PC_W-1:0]   LutWData;
    logic              BranchAbs, Done, Flag;
    logic [PC_W-1:0]   Target;

    logic              r_start_d = 1'b0;
    int                errors = 0;
    int                checks = 0;

    branch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
        .BrOp(BrOp), .BrRel(BrRel), .LutIdx(LutIdx), .FlagWe(FlagWe),
        .ALU_flag(ALU_flag), .Halt(Halt), .LutWe(LutWe), .LutWAddr(LutWAddr),
        .LutWData(LutWData), .BranchAbs(BranchAbs), .Target(Target),
        .Done(Done), .Flag(Flag)
    );

    always #5 Clk = ~Clk;

    // Program counter model: zeroed while Start is (or just was) high,
    // otherwise loads Target on BranchAbs or increments.
    always @(posedge Clk) begin
        r_start_d <= Start;
        if (Start || r_start_d)  ProgCtr <= '0;
        else if (BranchAbs)      ProgCtr <= Target;
        else                     ProgCtr <= ProgCtr + 1'b1;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; Start = 0; BrOp = 2'b00; BrRel = 0; LutIdx = '0; FlagWe = 0;
        ALU_flag = 0; Halt = 0; LutWe = 0; LutWAddr = '0; LutWData = '0;
        tick(); tick(); tick();
        Reset = 0;
        #3;
        checks++; if (Flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b exp 0", Flag); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", Done); end
        checks++; if (BranchAbs !== 1'b1 || Target !== ProgCtr) begin errors++; $display("FAIL idle_hold: babs=%b tgt=%0d exp babs=1 tgt=%0d", BranchAbs, Target, ProgCtr); end
        tick();
    endtask

    task automatic test_start();
        Start = 1;
        tick();
        #3;
        checks++; if (BranchAbs !== 1'b0) begin errors++; $display("FAIL start_babs: got %b exp 0", BranchAbs); end
        tick();
        Start = 0;
        #3;
        checks++; if (BranchAbs !== 1'b0) begin errors++; $display("FAIL start_babs2: got %b exp 0", BranchAbs); end
        tick();
        #3;
        checks++; if (ProgCtr !== 10'd0 || BranchAbs !== 1'b0) begin errors++; $display("FAIL run_pc0: pc=%0d babs=%b exp pc=0 babs=0", ProgCtr, BranchAbs); end
        tick(); tick();
        #3;
        checks++; if (ProgCtr !== 10'd2 || Done !== 1'b0) begin errors++; $display("FAIL run_pc2: pc=%0d done=%b exp pc=2 done=0", ProgCtr, Done); end
        tick();
    endtask

    task automatic test_lut_abs();
        LutWe = 1; LutWAddr = 4'd3; LutWData = 10'd200; LutIdx = 4'd5;
        tick();
        LutWAddr = 4'd5; LutWData = 10'd77;
        #3;
        checks++; if (Target !== 10'd0) begin errors++; $display("FAIL lut_same_cycle: got %0d exp 0", Target); end
        tick();
        LutWe = 0;
        #3;
        checks++; if (Target !== 10'd77) begin errors++; $display("FAIL lut_readback: got %0d exp 77", Target); end
        tick();
        BrOp = 2'b01; BrRel = 0; LutIdx = 4'd3;
        #3;
        checks++; if (BranchAbs !== 1'b1 || Target !== 10'd200) begin errors++; $display("FAIL abs_jump: babs=%b tgt=%0d exp babs=1 tgt=200", BranchAbs, Target); end
        tick();
        BrOp = 2'b00;
        #3;
        checks++; if (ProgCtr !== 10'd200) begin errors++; $display("FAIL abs_jump_pc: got %0d exp 200", ProgCtr); end
        tick();
    endtask

    task automatic test_flag();
        FlagWe = 1; ALU_flag = 1; BrOp = 2'b10; LutIdx = 4'd3;
        #3;
        checks++; if (BranchAbs !== 1'b0 || Flag !== 1'b0) begin errors++; $display("FAIL flag_old: babs=%b flag=%b exp babs=0 flag=0", BranchAbs, Flag); end
        tick();
        FlagWe = 0; ALU_flag = 0;
        #3;
        checks++; if (BranchAbs !== 1'b1 || Flag !== 1'b1) begin errors++; $display("FAIL flag_new: babs=%b flag=%b exp babs=1 flag=1", BranchAbs, Flag); end
        BrOp = 2'b11;
        #1;
        checks++; if (BranchAbs !== 1'b0) begin errors++; $display("FAIL brop11_set: got %b exp 0", BranchAbs); end
        BrOp = 2'b00;
        tick();
        FlagWe = 1; ALU_flag = 0;
        tick();
        FlagWe = 0; BrOp = 2'b11;
        #3;
        checks++; if (BranchAbs !== 1'b1 || Flag !== 1'b0) begin errors++; $display("FAIL brop11_clr: babs=%b flag=%b exp babs=1 flag=0", BranchAbs, Flag); end
        BrOp = 2'b00;
        tick();
    endtask

    task automatic test_relative();
        LutWe = 1; LutWAddr = 4'd1; LutWData = 10'h3FE;
        tick();
        LutWAddr = 4'd2; LutWData = 10'd1;
        tick();
        LutWAddr = 4'd4; LutWData = 10'd5;
        tick();
        LutWe = 0; BrOp = 2'b01; BrRel = 0; LutIdx = 4'd2;
        tick();
        BrRel = 1; LutIdx = 4'd1;
        #3;
        checks++; if (ProgCtr !== 10'd1 || Target !== 10'h3FF) begin errors++; $display("FAIL rel_wrap: pc=%0d tgt=%h exp pc=1 tgt=3ff", ProgCtr, Target); end
        tick();
        BrRel = 0; LutIdx = 4'd4;
        #3;
        checks++; if (ProgCtr !== 10'h3FF) begin errors++; $display("FAIL rel_wrap_pc: got %h exp 3ff", ProgCtr); end
        tick();
        BrRel = 1; LutIdx = 4'd1;
        #3;
        checks++; if (ProgCtr !== 10'd5 || Target !== 10'd3) begin errors++; $display("FAIL rel_back: pc=%0d tgt=%0d exp pc=5 tgt=3", ProgCtr, Target); end
        tick();
        BrOp = 2'b00; BrRel = 0;
        #3;
        checks++; if (ProgCtr !== 10'd3) begin errors++; $display("FAIL rel_back_pc: got %0d exp 3", ProgCtr); end
        tick();
    endtask

    task automatic test_halt();
        LutWe = 1; LutWAddr = 4'd6; LutWData = 10'd40;
        tick();
        LutWe = 0; BrOp = 2'b01; LutIdx = 4'd6;
        tick();
        Halt = 1; LutIdx = 4'd3;
        #3;
        checks++; if (BranchAbs !== 1'b1 || Target !== 10'd40 || Done !== 1'b0) begin errors++; $display("FAIL halt_beats_br: babs=%b tgt=%0d done=%b exp 1/40/0", BranchAbs, Target, Done); end
        tick();
        Halt = 0; BrOp = 2'b00;
        #3;
        checks++; if (Done !== 1'b1 || ProgCtr !== 10'd40 || BranchAbs !== 1'b1) begin errors++; $display("FAIL halted: done=%b pc=%0d babs=%b exp 1/40/1", Done, ProgCtr, BranchAbs); end
        tick();
        Start = 1;
        #3;
        checks++; if (ProgCtr !== 10'd40 || Done !== 1'b1) begin errors++; $display("FAIL halt_hold: pc=%0d done=%b exp 40/1", ProgCtr, Done); end
        tick();
        #3;
        checks++; if (Done !== 1'b0 || ProgCtr !== 10'd0 || BranchAbs !== 1'b0) begin errors++; $display("FAIL restart: done=%b pc=%0d babs=%b exp 0/0/0", Done, ProgCtr, BranchAbs); end
        Start = 0;
        tick();
        #3;
        checks++; if (ProgCtr !== 10'd0 || Done !== 1'b0) begin errors++; $display("FAIL restart_run: pc=%0d done=%b exp 0/0", ProgCtr, Done); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [PC_W-1:0] held;
        FlagWe = 1; ALU_flag = 1;
        tick();
        FlagWe = 0; ALU_flag = 0;
        #3;
        checks++; if (Flag !== 1'b1) begin errors++; $display("FAIL pre_reset_flag: got %b exp 1", Flag); end
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        #3;
        checks++; if (Flag !== 1'b0 || Done !== 1'b0 || BranchAbs !== 1'b1) begin errors++; $display("FAIL mid_reset: flag=%b done=%b babs=%b exp 0/0/1", Flag, Done, BranchAbs); end
        held = ProgCtr;
        tick();
        #3;
        checks++; if (ProgCtr !== held) begin errors++; $display("FAIL mid_reset_hold: pc=%0d exp %0d", ProgCtr, held); end
        Start = 1; LutIdx = 4'd3;
        tick();
        #3;
        checks++; if (Target !== 10'd0) begin errors++; $display("FAIL lut_clear3: got %0d exp 0", Target); end
        LutIdx = 4'd6;
        #1;
        checks++; if (Target !== 10'd0) begin errors++; $display("FAIL lut_clear6: got %0d exp 0", Target); end
        Start = 0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_start();
        test_lut_abs();
        test_flag();
        test_relative();
        test_halt();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
